pipeline_seq_mc: RTL and testbench

Multichannel successor to the single-sample pipeline sequencer. It accepts frames of `n_audio_channels` samples and buffers them in a small FIFO. Each frame is run through the shared DSP core one channel at a time, and the results are reassembled into an output frame. It sits between the audio I/O front end and the DSP core, and adds overrun accounting, a core-response watchdog and a per-frame bypass mode.

---
 rtl/pipeline_seq_mc.sv | 173 +++++++++++++++++
 tb/tb_pipeline_seq_mc.sv | 241 ++++++++++++++++++++++++
 2 files changed

// File: rtl/pipeline_seq_mc.sv
// Multichannel frame sequencer: buffers input frames, runs each channel through
// a shared DSP core with a response watchdog, and reassembles output frames.
module pipeline_seq_mc #(
  parameter int unsigned data_width       = 16,
  parameter int unsigned n_audio_channels = 2,
  parameter int unsigned fifo_depth       = 4,
  parameter int unsigned timeout_cycles   = 4096
) (
  input  logic                                        clk,
  input  logic                                        reset,
  input  logic [n_audio_channels*data_width-1:0]      in_frame,
  input  logic                                        in_valid,
  output logic                                        in_ready,
  input  logic                                        bypass,
  output logic                                        core_tick,
  output logic [data_width-1:0]                       core_sample_in,
  output logic [((n_audio_channels > 1) ? $clog2(n_audio_channels) : 1)-1:0] core_channel,
  input  logic                                        core_ready,
  input  logic [data_width-1:0]                       core_sample_out,
  output logic [n_audio_channels*data_width-1:0]      out_frame,
  output logic                                        out_valid,
  output logic                                        idle,
  output logic                                        error,
  input  logic                                        clear_error,
  output logic [15:0]                                 overrun_count,
  output logic [31:0]                                 frame_count
);

  localparam int unsigned ch_w  = (n_audio_channels > 1) ? $clog2(n_audio_channels) : 1;
  localparam int unsigned ptr_w = $clog2(fifo_depth);
  localparam int unsigned cnt_w = ptr_w + 1;
  localparam int unsigned wd_w  = $clog2(timeout_cycles + 1);

  typedef logic [n_audio_channels-1:0][data_width-1:0] frame_t;
  typedef enum logic [2:0] {S_IDLE, S_LAUNCH, S_WAIT, S_EMIT, S_ERROR} state_t;

  state_t            state;
  frame_t            mem [fifo_depth];
  frame_t            head_c;
  frame_t            obuf;
  frame_t            buf_upd_c;
  logic [ptr_w-1:0]  rd_ptr;
  logic [ptr_w-1:0]  wr_ptr;
  logic [cnt_w-1:0]  count;
  logic [ch_w-1:0]   ch;
  logic [ch_w-1:0]   ch_nxt_c;
  logic [wd_w-1:0]   wd;
  logic              full_c;
  logic              empty_c;
  logic              push_c;
  logic              pop_c;
  logic              drop_c;
  logic              latch_c;
  logic              last_c;
  logic              flush_c;

  assign head_c   = mem[rd_ptr];
  assign full_c   = (count == cnt_w'(fifo_depth));
  assign empty_c  = (count == '0);
  assign in_ready = !full_c && (state != S_ERROR);
  assign idle     = (state == S_IDLE) && empty_c;
  assign push_c   = in_valid && in_ready;
  assign drop_c   = in_valid && !in_ready;
  assign last_c   = (ch == ch_w'(n_audio_channels - 1));
  assign ch_nxt_c = ch + ch_w'(1);
  assign flush_c  = (state == S_ERROR) && clear_error;
  // The first WAIT cycle (wd == 0) sees a stale ready from the core and is ignored
  assign latch_c  = (state == S_WAIT) && (wd != '0) && core_ready;
  assign pop_c    = ((state == S_IDLE) && !empty_c && bypass) || (latch_c && last_c);

  // Result buffer with the current channel's core result merged in
  always_comb begin
    buf_upd_c     = obuf;
    buf_upd_c[ch] = core_sample_out;
  end

  always_ff @(posedge clk) begin
    if (push_c) mem[wr_ptr] <= in_frame;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state          <= S_IDLE;
      rd_ptr         <= '0;
      wr_ptr         <= '0;
      count          <= '0;
      ch             <= '0;
      wd             <= '0;
      obuf           <= '0;
      core_tick      <= 1'b0;
      core_sample_in <= '0;
      core_channel   <= '0;
      out_frame      <= '0;
      out_valid      <= 1'b0;
      error          <= 1'b0;
      overrun_count  <= '0;
      frame_count    <= '0;
    end else begin
      core_tick <= 1'b0;
      out_valid <= 1'b0;

      if (flush_c) begin
        rd_ptr <= '0;
        wr_ptr <= '0;
        count  <= '0;
      end else begin
        if (push_c) wr_ptr <= wr_ptr + ptr_w'(1);
        if (pop_c)  rd_ptr <= rd_ptr + ptr_w'(1);
        count <= count + cnt_w'(push_c) - cnt_w'(pop_c);
      end

      if (drop_c && (overrun_count != 16'hFFFF)) overrun_count <= overrun_count + 16'd1;

      // Registered outputs are set on the transition into the state that owns them
      case (state)
        S_IDLE: begin
          if (!empty_c) begin
            if (bypass) begin
              obuf        <= head_c;
              out_frame   <= head_c;
              out_valid   <= 1'b1;
              frame_count <= frame_count + 32'd1;
              state       <= S_EMIT;
            end else begin
              ch             <= '0;
              core_tick      <= 1'b1;
              core_sample_in <= head_c[0];
              core_channel   <= '0;
              state          <= S_LAUNCH;
            end
          end
        end
        S_LAUNCH: begin
          wd    <= '0;
          state <= S_WAIT;
        end
        S_WAIT: begin
          if (latch_c) begin
            obuf <= buf_upd_c;
            if (last_c) begin
              out_frame   <= buf_upd_c;
              out_valid   <= 1'b1;
              frame_count <= frame_count + 32'd1;
              state       <= S_EMIT;
            end else begin
              ch             <= ch_nxt_c;
              core_tick      <= 1'b1;
              core_sample_in <= head_c[ch_nxt_c];
              core_channel   <= ch_nxt_c;
              state          <= S_LAUNCH;
            end
          end else if (wd == wd_w'(timeout_cycles - 1)) begin
            error <= 1'b1;
            state <= S_ERROR;
          end else begin
            wd <= wd + wd_w'(1);
          end
        end
        S_EMIT: begin
          state <= S_IDLE;
        end
        S_ERROR: begin
          if (clear_error) begin
            error <= 1'b0;
            state <= S_IDLE;
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_pipeline_seq_mc.sv
// Scoreboard bench for pipeline_seq_mc: directed frames with hand-computed results,
// a doubling core model, and a forked monitor that checks every out_valid pulse.
module tb_pipeline_seq_mc;

  localparam int unsigned DW  = 16;
  localparam int unsigned NCH = 2;
  localparam int unsigned FW  = DW * NCH;

  logic          clk = 1'b0;
  logic          reset;
  logic [FW-1:0] in_frame;
  logic          in_valid;
  logic          in_ready;
  logic          bypass;
  logic          core_tick;
  logic [DW-1:0] core_sample_in;
  logic [0:0]    core_channel;
  logic          core_ready;
  logic [DW-1:0] core_sample_out;
  logic [FW-1:0] out_frame;
  logic          out_valid;
  logic          idle;
  logic          error;
  logic          clear_error;
  logic [15:0]   overrun_count;
  logic [31:0]   frame_count;
  logic          stall;

  pipeline_seq_mc #(
    .data_width(DW), .n_audio_channels(NCH), .fifo_depth(4), .timeout_cycles(16)
  ) dut (
    .clk(clk), .reset(reset), .in_frame(in_frame), .in_valid(in_valid),
    .in_ready(in_ready), .bypass(bypass), .core_tick(core_tick),
    .core_sample_in(core_sample_in), .core_channel(core_channel),
    .core_ready(core_ready), .core_sample_out(core_sample_out),
    .out_frame(out_frame), .out_valid(out_valid), .idle(idle), .error(error),
    .clear_error(clear_error), .overrun_count(overrun_count), .frame_count(frame_count)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // Core model: doubles the sample captured on core_tick; stall holds ready low
  assign core_ready = !stall;
  always @(posedge clk) begin
    if (reset) core_sample_out <= '0;
    else if (core_tick) core_sample_out <= DW'(core_sample_in << 1);
  end

  typedef struct {
    logic [FW-1:0] frame;
    int            at;
  } exp_t;

  exp_t q[$];
  int   n_cmp  = 0;
  int   n_fail = 0;
  int   ticks  = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic wait_until(input int c);
    while (cyc < c) @(negedge clk);
  endtask

  // Offer one frame for a single cycle; lat < 0 means the output cycle is not checked
  task automatic send(input logic [FW-1:0] f, input logic acc, input logic push,
                      input logic [FW-1:0] ef, input int lat, output int t);
    exp_t e;
    @(negedge clk);
    in_frame = f;
    in_valid = 1'b1;
    t = cyc;
    check("in_ready_on_offer", 64'(in_ready), 64'(acc));
    if (acc && push) begin
      e.frame = ef;
      e.at    = (lat < 0) ? -1 : t + lat;
      q.push_back(e);
    end
    @(posedge clk);
    #1;
    in_valid = 1'b0;
  endtask

  task automatic wait_drain(input int bound);
    int n = 0;
    while (q.size() != 0 && n < bound) begin
      @(negedge clk);
      n++;
    end
    check("scoreboard_drain", 64'(q.size()), 64'd0);
  endtask

  task automatic check_reset_values(input string tag);
    check({tag, "_in_ready"}, 64'(in_ready), 64'd1);
    check({tag, "_idle"}, 64'(idle), 64'd1);
    check({tag, "_error"}, 64'(error), 64'd0);
    check({tag, "_out_valid"}, 64'(out_valid), 64'd0);
    check({tag, "_core_tick"}, 64'(core_tick), 64'd0);
    check({tag, "_core_sample_in"}, 64'(core_sample_in), 64'd0);
    check({tag, "_core_channel"}, 64'(core_channel), 64'd0);
    check({tag, "_out_frame"}, 64'(out_frame), 64'd0);
    check({tag, "_overrun"}, 64'(overrun_count), 64'd0);
    check({tag, "_frame_count"}, 64'(frame_count), 64'd0);
  endtask

  logic [FW-1:0] burst_in  [6];
  logic [FW-1:0] burst_out [6];

  initial begin
    int t;
    int t0;
    reset       = 1'b1;
    in_frame    = '0;
    in_valid    = 1'b0;
    bypass      = 1'b0;
    clear_error = 1'b0;
    stall       = 1'b0;

    burst_in[0] = 32'h0011_0001; burst_out[0] = 32'h0022_0002;
    burst_in[1] = 32'h0012_0002; burst_out[1] = 32'h0024_0004;
    burst_in[2] = 32'h0013_0003; burst_out[2] = 32'h0026_0006;
    burst_in[3] = 32'h0014_0004; burst_out[3] = 32'h0028_0008;
    burst_in[4] = 32'h0015_0005; burst_out[4] = 32'h0;
    burst_in[5] = 32'h0016_0006; burst_out[5] = 32'h0;

    // Monitor: every out_valid pulse must match the head of the scoreboard
    fork
      forever begin
        exp_t e;
        @(negedge clk);
        if (core_tick) ticks++;
        if (!reset && out_valid) begin
          if (q.size() == 0) begin
            check("unexpected_out_valid", 64'(out_frame), 64'hDEAD);
          end else begin
            e = q.pop_front();
            check("out_frame", 64'(out_frame), 64'(e.frame));
            if (e.at >= 0) check("out_valid_cycle", 64'(cyc), 64'(e.at));
          end
        end
      end
    join_none

    repeat (3) @(negedge clk);
    reset = 1'b0;
    check_reset_values("reset");

    // Basic core-path frame: 2 channels, each doubled, out_valid at T+8
    t0 = ticks;
    send(32'h0020_0010, 1'b1, 1'b1, 32'h0040_0020, 8, t);
    wait_drain(30);
    check("basic_frame_count", 64'(frame_count), 64'd1);
    check("basic_ticks", 64'(ticks - t0), 64'd2);

    // Bypass: frame copied unchanged at T+2, no core ticks
    t0 = ticks;
    bypass = 1'b1;
    send(32'hABCD_1234, 1'b1, 1'b1, 32'hABCD_1234, 2, t);
    wait_drain(30);
    bypass = 1'b0;
    check("bypass_ticks", 64'(ticks - t0), 64'd0);
    check("bypass_frame_count", 64'(frame_count), 64'd2);

    // Overrun: stalled core, 6 back-to-back frames, only 4 fit
    t0 = ticks;
    stall = 1'b1;
    for (int i = 0; i < 6; i++) send(burst_in[i], (i < 4), 1'b1, burst_out[i], -1, t);
    check("overrun_count_burst", 64'(overrun_count), 64'd2);
    check("in_ready_full", 64'(in_ready), 64'd0);
    stall = 1'b0;
    wait_drain(120);
    check("burst_frame_count", 64'(frame_count), 64'd6);
    check("burst_ticks", 64'(ticks - t0), 64'd8);

    // Watchdog: 16 WAIT cycles without ready -> ERROR at T+19
    stall = 1'b1;
    send(32'h0031_0030, 1'b1, 1'b0, '0, -1, t);
    wait_until(t + 18);
    check("wd_error_before", 64'(error), 64'd0);
    wait_until(t + 19);
    check("wd_error_set", 64'(error), 64'd1);
    check("wd_in_ready", 64'(in_ready), 64'd0);
    send(32'h0033_0032, 1'b0, 1'b0, '0, -1, t);
    check("wd_overrun", 64'(overrun_count), 64'd3);
    @(negedge clk);
    clear_error = 1'b1;
    @(negedge clk);
    clear_error = 1'b0;
    check("clear_idle", 64'(idle), 64'd1);
    check("clear_error", 64'(error), 64'd0);
    check("clear_in_ready", 64'(in_ready), 64'd1);
    stall = 1'b0;
    send(32'h0041_0040, 1'b1, 1'b1, 32'h0082_0080, 8, t);
    wait_drain(30);
    check("wd_frame_count", 64'(frame_count), 64'd7);

    // Reset during WAIT of channel 1 aborts the frame with no out_valid
    send(32'h0051_0050, 1'b1, 1'b0, '0, -1, t);
    wait_until(t + 6);
    check("midreset_channel1", 64'(core_channel), 64'd1);
    reset = 1'b1;
    @(negedge clk);
    check_reset_values("midreset");
    reset = 1'b0;
    repeat (12) @(negedge clk);
    check("midreset_no_output", 64'(frame_count), 64'd0);

    // Saturation: hold a frame offered in ERROR for 65540 cycles
    stall = 1'b1;
    send(32'h0061_0060, 1'b1, 1'b0, '0, -1, t);
    wait_until(t + 19);
    check("sat_error", 64'(error), 64'd1);
    in_valid = 1'b1;
    repeat (65534) @(negedge clk);
    check("sat_fffe", 64'(overrun_count), 64'hFFFE);
    @(negedge clk);
    check("sat_ffff", 64'(overrun_count), 64'hFFFF);
    repeat (5) @(negedge clk);
    check("sat_hold", 64'(overrun_count), 64'hFFFF);
    in_valid = 1'b0;
    clear_error = 1'b1;
    @(negedge clk);
    clear_error = 1'b0;
    stall = 1'b0;
    check("sat_cleared_idle", 64'(idle), 64'd1);
    wait_drain(10);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
